// File: rtl/rv64g_l2_pkg.sv
// Shared L2 constants and the refill sequencer state encoding.
package rv64g_l2_pkg;

  localparam int WORD_W    = 64;
  localparam int BE_W      = 8;
  localparam int CNT_W     = 3;
  localparam int BEATS_DEF = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RD_ADDR = 3'd1;
  localparam state_t ST_RD_DATA = 3'd2;
  localparam state_t ST_FILL    = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

endpackage

// File: rtl/rv64g_l2_refill_seq.sv
// L2 line refill sequencer: optional victim read-out to the writeback port,
// then one array write per accepted fill beat, then a single done pulse.
module rv64g_l2_refill_seq
  import rv64g_l2_pkg::*;
#(
  parameter int IDX_W = 8,
  parameter int WAY_W = 4,
  parameter int TAG_W = 50,
  parameter int BEATS = BEATS_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_evict_i,
  input  logic [IDX_W-1:0]    req_index_i,
  input  logic [WAY_W-1:0]    req_way_i,
  input  logic [TAG_W-1:0]    req_tag_i,
  input  logic                fill_valid_i,
  output logic                fill_ready_o,
  input  logic [WORD_W-1:0]   fill_data_i,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [WORD_W-1:0]   wb_data_o,
  output logic                wb_last_o,
  output logic [IDX_W-1:0]    arr_index_o,
  output logic [CNT_W-1:0]    arr_word_sel_o,
  output logic [WAY_W-1:0]    arr_way_sel_o,
  output logic                arr_write_en_o,
  output logic [BE_W-1:0]     arr_be_o,
  output logic [TAG_W-1:0]    arr_tag_o,
  output logic [WORD_W-1:0]   arr_wdata_o,
  input  logic [WORD_W-1:0]   arr_rdata_i,
  output logic                busy_o,
  output logic                done_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]  wb_data_q;
  logic [IDX_W-1:0]   idx_q;
  logic [WAY_W-1:0]   way_q;
  logic [TAG_W-1:0]   tag_q;
  logic               req_hs, wb_hs, fill_hs;

  // Ready is held low while reset is asserted so nothing is offered mid-reset.
  assign req_ready_o  = (state_q == ST_IDLE) && rst_ni;
  assign req_hs       = req_valid_i && req_ready_o;
  assign wb_valid_o   = (state_q == ST_RD_DATA);
  assign wb_hs        = wb_valid_o && wb_ready_i;
  assign fill_ready_o = (state_q == ST_FILL);
  assign fill_hs      = fill_ready_o && fill_valid_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_hs) begin
          cnt_d   = '0;
          state_d = req_evict_i ? ST_RD_ADDR : ST_FILL;
        end
      end
      ST_RD_ADDR: state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        if (wb_hs) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = ST_FILL;
          end else begin
            cnt_d   = cnt_q + 3'd1;
            state_d = ST_RD_ADDR;
          end
        end
      end
      ST_FILL: begin
        if (fill_hs) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + 3'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      wb_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // The array read addressed in RD_ADDR is captured as RD_DATA is entered.
      if (state_q == ST_RD_ADDR) wb_data_q <= arr_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (req_hs) begin
      idx_q <= req_index_i;
      way_q <= req_way_i;
      tag_q <= req_tag_i;
    end
  end

  assign wb_data_o      = wb_data_q;
  assign wb_last_o      = wb_valid_o && (cnt_q == LAST);
  assign arr_index_o    = idx_q;
  assign arr_way_sel_o  = way_q;
  assign arr_word_sel_o = cnt_q;
  assign arr_write_en_o = fill_hs;
  assign arr_be_o       = fill_hs ? {BE_W{1'b1}} : {BE_W{1'b0}};
  assign arr_tag_o      = tag_q;
  assign arr_wdata_o    = fill_data_i;
  assign busy_o         = (state_q != ST_IDLE);
  assign done_o         = (state_q == ST_DONE);

endmodule

// File: tb/tb_rv64g_l2_refill_seq.sv
// Directed bench for the L2 refill sequencer with a one-set array model.
module tb_rv64g_l2_refill_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_evict = 1'b0;
  logic [7:0]  req_index = '0;
  logic [3:0]  req_way = '0;
  logic [49:0] req_tag = '0;
  logic        fill_valid = 1'b0, fill_ready;
  logic [63:0] fill_data = '0;
  logic        wb_valid, wb_ready = 1'b0, wb_last;
  logic [63:0] wb_data;
  logic [7:0]  arr_index;
  logic [2:0]  arr_word_sel;
  logic [3:0]  arr_way_sel;
  logic        arr_write_en;
  logic [7:0]  arr_be;
  logic [49:0] arr_tag, exp_tag;
  logic [63:0] arr_wdata, arr_rdata;
  logic        busy, done;

  int tests = 0;
  int fails = 0;
  int nw = 0;
  int attr_err = 0;
  logic [63:0] mem [0:7];
  logic [2:0]  wsel_log [0:63];

  always #5 clk = ~clk;

  rv64g_l2_refill_seq dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_evict_i(req_evict),
    .req_index_i(req_index), .req_way_i(req_way), .req_tag_i(req_tag),
    .fill_valid_i(fill_valid), .fill_ready_o(fill_ready), .fill_data_i(fill_data),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_data_o(wb_data), .wb_last_o(wb_last),
    .arr_index_o(arr_index), .arr_word_sel_o(arr_word_sel), .arr_way_sel_o(arr_way_sel),
    .arr_write_en_o(arr_write_en), .arr_be_o(arr_be), .arr_tag_o(arr_tag),
    .arr_wdata_o(arr_wdata), .arr_rdata_i(arr_rdata),
    .busy_o(busy), .done_o(done)
  );

  // Array model for set 0x10 / way 5: combinational read, write on the clock edge.
  assign arr_rdata = mem[arr_word_sel];

  always @(posedge clk) begin
    if (arr_write_en) begin
      mem[arr_word_sel] <= arr_wdata;
      wsel_log[nw]      <= arr_word_sel;
      nw                <= nw + 1;
      if (arr_index !== 8'h10 || arr_way_sel !== 4'd5 || arr_tag !== exp_tag || arr_be !== 8'hFF)
        attr_err <= attr_err + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  logic [63:0] held;
  int nw_base;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;

    // Reset state
    sample();
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, 64'h0);
    chk("rst_fill_ready", fill_ready, 1'b0);
    chk("rst_write_en", arr_write_en, 1'b0);
    chk("rst_done", done, 1'b0);
    step();
    rst_n = 1'b1;
    sample();
    chk("idle_req_ready", req_ready, 1'b1);
    step();

    // No-evict fill, contiguous beats
    exp_tag   = 50'h123456789ABC;
    req_valid = 1'b1; req_evict = 1'b0; req_index = 8'h10; req_way = 4'd5; req_tag = exp_tag;
    fill_valid = 1'b1; fill_data = 64'h1000;
    sample();
    chk("a_fill_ignored_idle", arr_write_en, 1'b0);
    step();
    req_valid = 1'b0; req_index = 8'h00; req_way = 4'd0; req_tag = '0;
    for (int k = 0; k < 8; k++) begin
      fill_data = 64'h1000 + 64'(k);
      sample();
      chk("a_fill_ready", fill_ready, 1'b1);
      chk("a_write_en", arr_write_en, 1'b1);
      chk("a_word_sel", arr_word_sel, 64'(k));
      chk("a_wdata", arr_wdata, 64'h1000 + 64'(k));
      step();
    end
    fill_valid = 1'b0;
    sample();
    chk("a_done", done, 1'b1);
    chk("a_done_no_write", arr_write_en, 1'b0);
    step();
    sample();
    chk("a_done_one_cycle", done, 1'b0);
    chk("a_back_idle", req_ready, 1'b1);
    chk("a_nwrites", nw, 8);
    for (int k = 0; k < 8; k++) chk("a_wsel_log", wsel_log[k], 64'(k));
    for (int k = 0; k < 8; k++) chk("a_mem", mem[k], 64'h1000 + 64'(k));
    step();

    // Evict with a stall on word 3, then gapped fill
    exp_tag   = 50'h2_0000_0000_0001;
    req_valid = 1'b1; req_evict = 1'b1; req_index = 8'h10; req_way = 4'd5; req_tag = exp_tag;
    wb_ready  = 1'b1;
    step();
    req_valid = 1'b0; req_evict = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) wb_ready = 1'b0;
      sample();
      chk("b_rd_addr_no_valid", wb_valid, 1'b0);
      chk("b_rd_addr_sel", arr_word_sel, 64'(k));
      chk("b_rd_addr_no_write", arr_write_en, 1'b0);
      step();
      sample();
      chk("b_wb_valid", wb_valid, 1'b1);
      chk("b_wb_data", wb_data, 64'h1000 + 64'(k));
      chk("b_wb_last", wb_last, (k == 7) ? 1'b1 : 1'b0);
      if (k == 3) begin
        held = wb_data;
        for (int s = 0; s < 5; s++) begin
          step();
          sample();
          chk("c_stall_valid", wb_valid, 1'b1);
          chk("c_stall_data", wb_data, held);
          chk("c_stall_sel", arr_word_sel, 64'd3);
          chk("c_stall_no_write", arr_write_en, 1'b0);
        end
        wb_ready = 1'b1;
      end
      step();
    end
    wb_ready = 1'b0;
    sample();
    chk("b_in_fill", fill_ready, 1'b1);
    chk("b_evict_no_writes", nw, 8);
    for (int k = 0; k < 8; k++) begin
      fill_valid = 1'b0;
      fill_data  = 64'hDEAD;
      sample();
      chk("d_gap_no_write", arr_write_en, 1'b0);
      step();
      fill_valid = 1'b1;
      fill_data  = 64'h2000 + 64'(k);
      sample();
      chk("d_write_en", arr_write_en, 1'b1);
      chk("d_word_sel", arr_word_sel, 64'(k));
      step();
    end
    fill_valid = 1'b0;
    sample();
    chk("d_done", done, 1'b1);
    chk("d_nwrites", nw, 16);
    chk("d_mem7", mem[7], 64'h2007);
    step();
    step();

    // Reset in the middle of a fill
    exp_tag   = 50'h3;
    req_valid = 1'b1; req_evict = 1'b0; req_index = 8'h10; req_way = 4'd5; req_tag = exp_tag;
    step();
    req_valid  = 1'b0;
    fill_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      fill_data = 64'h3000 + 64'(k);
      step();
    end
    fill_data = 64'h3004;
    nw_base   = nw;
    rst_n     = 1'b0;
    #1;
    chk("e_async_write_en", arr_write_en, 1'b0);
    chk("e_async_fill_ready", fill_ready, 1'b0);
    sample();
    chk("e_rst_busy", busy, 1'b0);
    chk("e_rst_wb_data", wb_data, 64'h0);
    chk("e_rst_req_ready", req_ready, 1'b0);
    step();
    rst_n = 1'b1;
    sample();
    chk("e_writes_before_rst", nw_base, 20);
    chk("e_no_write_after_rst", nw, 20);
    chk("e_req_ready", req_ready, 1'b1);
    chk("e_fill_ignored", arr_write_en, 1'b0);
    chk("e_mem4_untouched", mem[4], 64'h2004);
    fill_valid = 1'b0;
    req_valid  = 1'b1; req_evict = 1'b0;
    step();
    req_valid = 1'b0;
    sample();
    chk("e_new_req_busy", busy, 1'b1);
    chk("e_new_req_fill", fill_ready, 1'b1);
    chk("e_new_req_sel", arr_word_sel, 64'd0);
    chk("attr_errors", attr_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rv64g_l2_refill_seq.md
RV64G_L2_REFILL_SEQ -- requirements
Module: rv64g_l2_refill_seq

Interface
REQ-001 SHALL have parameter IDX_W, default 8, set-index width (256 sets).
REQ-002 SHALL have parameter WAY_W, default 4, way-select width (16 ways).
REQ-003 SHALL have parameter TAG_W, default 50, tag width.
REQ-004 SHALL have parameter BEATS, default 8, 64-bit words per line.
REQ-005 SHALL have ports, in order:
 - clk_i  in  1  sole clock, rising edge.
 - rst_ni  in  1  reset, asynchronous, active-low.
 - req_valid_i  in  1  refill request valid.
 - req_ready_o  out  1  request accepted when both high.
 - req_evict_i  in  1  read out victim line before fill.
 - req_index_i  in  IDX_W  target set.
 - req_way_i  in  WAY_W  target way.
 - req_tag_i  in  TAG_W  new tag.
 - fill_valid_i  in  1  fill beat valid.
 - fill_ready_o  out  1  fill beat accepted.
 - fill_data_i  in  64  fill beat data.
 - wb_valid_o  out  1  victim word valid.
 - wb_ready_i  in  1  victim word consumed.
 - wb_data_o  out  64  victim word.
 - wb_last_o  out  1  final victim word.
 - arr_index_o  out  IDX_W  to arrays index.
 - arr_word_sel_o  out  3  to arrays word select.
 - arr_way_sel_o  out  WAY_W  to arrays way select.
 - arr_write_en_o  out  1  to arrays write enable.
 - arr_be_o  out  8  to arrays byte enables.
 - arr_tag_o  out  TAG_W  to arrays tag input.
 - arr_wdata_o  out  64  to arrays write data.
 - arr_rdata_i  in  64  from arrays selected read data.
 - busy_o  out  1  high in any non-IDLE state.
 - done_o  out  1  one-cycle completion pulse.

Function
REQ-006 SHALL implement states IDLE, RD_ADDR, RD_DATA, FILL, DONE.
REQ-007 SHALL assert req_ready_o only in IDLE; on accept, latch index/way/tag/evict and clear beat counter to 0.
REQ-008 SHALL go IDLE->RD_ADDR on accept if req_evict_i=1, else IDLE->FILL.
REQ-009 RD_ADDR SHALL drive arr_word_sel_o=counter, write_en=0, and go to RD_DATA next cycle.
REQ-010 RD_DATA SHALL capture arr_rdata_i into wb_data_o on entry (first RD_DATA cycle only) and hold wb_valid_o=1 until wb_ready_i.
REQ-011 On wb handshake: counter<BEATS-1 -> counter+1, RD_ADDR; counter=BEATS-1 -> counter=0, FILL.
REQ-012 wb_last_o SHALL equal wb_valid_o AND counter=BEATS-1.
REQ-013 FILL SHALL drive fill_ready_o=1; per handshake, same cycle, arr_write_en_o=1, arr_word_sel_o=counter, arr_be_o=8'hFF, arr_wdata_o=fill_data_i, arr_tag_o=latched tag.
REQ-014 FILL handshake at counter=BEATS-1 SHALL go to DONE; otherwise counter+1.
REQ-015 DONE SHALL pulse done_o for exactly one cycle, then IDLE.
REQ-016 arr_index_o/arr_way_sel_o SHALL equal latched values in all non-IDLE states; arr_write_en_o SHALL be 0 outside FILL handshakes.
REQ-017 fill_valid_i outside FILL SHALL be ignored (fill_ready_o=0); wb_ready_i without wb_valid_o SHALL be ignored.
REQ-018 Counter SHALL be 3 bits, wrap never exercised (reset to 0 at phase boundaries).

Reset
REQ-019 rst_ni low SHALL force IDLE, counter=0, wb_data_o=0, all valid/ready/write_en/done outputs 0 except req_ready_o=1 after deassertion, immediately and asynchronously.
REQ-020 Reset mid-evict or mid-fill SHALL abandon the line with no further array write.

Structure
REQ-021 State enum, BEATS, and L2 width constants SHALL live in shared package rv64g_l2_pkg.
REQ-022 No sub-module; single FSM plus counter and tag/index/way/wb registers.

Verification
REQ-023 No-evict fill idx=8'h10 way=5 tag=50'h123456789ABC, beats 0x1000+k -> 8 writes word_sel 0..7, done_o at cycle after beat 7.
REQ-024 Evict idx=8'h10 way=5 after REQ-023 fill -> wb words 0x1000..0x1007, wb_last_o only on 0x1007, then FILL.
REQ-025 wb_ready_i held low 5 cycles on word 3 -> wb_data_o stable, no array access changes, counter held.
REQ-026 fill_valid_i gapped every other cycle -> exactly 8 writes, no write on idle cycles.
REQ-027 rst_ni pulsed after fill beat 3 -> outputs at reset values, no further writes, new request accepted.
